// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default
// geometry of the register file and the arbiter FSM state type.
package regfile_write_arbiter_pkg;

  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned RF_NUM_REG = 32;

  // ARB: serving requesters; CLEAR: walking x1..x(NUM_REG-1) with zero writes.
  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants a lone requester directly; when both
// request, the pointer decides, and after any accepted grant the pointer
// moves to the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant selection: lone requester wins, contention resolved by rr_ptr.
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Pointer update: favour the loser of the accepted grant next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      rr_ptr_d = ~grant_o[1];
    end
  end

  // Pointer register, starts favouring requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the core writeback
// (req0) and the debug/loader (req1). Writes to x0 are accepted but not
// issued. A clear command zeroes x1..x(NUM_REG-1), one register per cycle.
// The rf_* outputs are registered and drive WE3/A3/WD3 directly.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned NUM_REG = RF_NUM_REG,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REG - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                clr_busy_q;
  logic                clr_done_q;
  logic                rf_we_q;
  logic [ADDR_W-1:0]   rf_addr_q;
  logic [DATA_W-1:0]   rf_data_q;
  logic [CNT_W-1:0]    conflict_q;
  logic [CNT_W-1:0]    conflict_d;

  logic                arb_en;
  logic [1:0]          grant;
  logic                xfer;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   ({req1_valid, req0_valid}),
    .advance_i (arb_en),
    .grant_o   (grant)
  );

  // Handshake: requests are served only in ARB, and a clear command pre-empts them.
  always_comb begin
    arb_en     = (state_q == ST_ARB) && !clr_start;
    req0_ready = arb_en && grant[0];
    req1_ready = arb_en && grant[1];
    xfer       = req0_ready || req1_ready;
    win_addr   = grant[1] ? req1_addr : req0_addr;
    win_data   = grant[1] ? req1_data : req0_data;
  end

  // Contention statistics: count contested ARB cycles, saturating at all-ones.
  always_comb begin
    conflict_d = conflict_q;
    if (arb_en && req0_valid && req1_valid && (conflict_q != '1)) begin
      conflict_d = conflict_q + CNT_W'(1);
    end
  end

  // FSM with registered write-port and clear-status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      clr_cnt_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        ST_ARB: begin
          if (clr_start) begin
            state_q    <= ST_CLEAR;
            clr_busy_q <= 1'b1;
            clr_cnt_q  <= FIRST_REG;
            rf_we_q    <= 1'b0;
          end else if (xfer) begin
            // x0 writes complete the handshake but never reach WE3.
            rf_we_q   <= (win_addr != '0);
            rf_addr_q <= win_addr;
            rf_data_q <= win_data;
          end else begin
            rf_we_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          rf_we_q   <= 1'b1;
          rf_addr_q <= clr_cnt_q;
          rf_data_q <= '0;
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST_REG) begin
            state_q    <= ST_ARB;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign clr_busy     = clr_busy_q;
  assign clr_done     = clr_done_q;
  assign rf_we        = rf_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_data      = rf_data_q;
  assign conflict_cnt = conflict_q;

endmodule
